demux5: RTL and testbench

Registered 1-to-8 demultiplexer for 5-bit register-address fields in the RISC-V datapath; the write-side counterpart of the 8:1 5-bit address selector. A single 5-bit source value is steered, on a load strobe, into one of eight holding registers chosen by a 3-bit selector. Each load is announced by a one-cycle valid pulse on the target lane. Consumers in the multicycle control path read stable addresses from the holding registers across the following cycles.

---
 rtl/demux5.sv | 99 +++++++++
 tb/tb_demux5.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/demux5.sv
// demux5 - registered 1-to-8 demultiplexer for 5-bit register-address fields.
//
// Steers the source value In into one of eight holding registers selected by
// Sel whenever Load is sampled high. Each load raises a one-cycle one-hot
// pulse on Valid for the target lane, and LastSel records the lane index.
// All outputs come straight from flops.
//
// Optional feature macro: DEMUX5_CLEAR_EN
//   Adds the Clear port. Clear zeroes all lanes, Valid and LastSel at the
//   edge, except that a simultaneous Load still writes lane Sel.
//
// Ports:
//   clk            in   clock, rising edge active
//   reset_n        in   asynchronous active-low reset
//   In     [4:0]   in   source value
//   Sel    [2:0]   in   destination lane index
//   Load           in   write strobe
//   Clear          in   synchronous clear (DEMUX5_CLEAR_EN only)
//   Out0..Out7 [4:0] out holding registers
//   Valid  [7:0]   out  one-hot load pulse, bit i = lane i loaded last edge
//   LastSel [2:0]  out  most recently loaded lane
module demux5 (
   input  logic       clk,
   input  logic       reset_n,
   input  logic [4:0] In,
   input  logic [2:0] Sel,
   input  logic       Load,
`ifdef DEMUX5_CLEAR_EN
   input  logic       Clear,
`endif
   output logic [4:0] Out0,
   output logic [4:0] Out1,
   output logic [4:0] Out2,
   output logic [4:0] Out3,
   output logic [4:0] Out4,
   output logic [4:0] Out5,
   output logic [4:0] Out6,
   output logic [4:0] Out7,
   output logic [7:0] Valid,
   output logic [2:0] LastSel
);

   logic [4:0] lane_q [8];
   logic [4:0] lane_d [8];
   logic [7:0] valid_q, valid_d;
   logic [2:0] last_q, last_d;

   always_comb begin
      for (int unsigned i = 0; i < 8; i++) begin
         lane_d[i] = lane_q[i];
      end
      valid_d = '0;
      last_d  = last_q;

`ifdef DEMUX5_CLEAR_EN
      if (Clear) begin
         for (int unsigned i = 0; i < 8; i++) begin
            lane_d[i] = '0;
         end
         last_d = '0;
      end
`endif

      // Load is evaluated last so it overrides Clear on the selected lane.
      if (Load) begin
         lane_d[Sel] = In;
         valid_d     = 8'(1) << Sel;
         last_d      = Sel;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int unsigned i = 0; i < 8; i++) begin
            lane_q[i] <= '0;
         end
         valid_q <= '0;
         last_q  <= '0;
      end else begin
         for (int unsigned i = 0; i < 8; i++) begin
            lane_q[i] <= lane_d[i];
         end
         valid_q <= valid_d;
         last_q  <= last_d;
      end
   end

   assign Out0    = lane_q[0];
   assign Out1    = lane_q[1];
   assign Out2    = lane_q[2];
   assign Out3    = lane_q[3];
   assign Out4    = lane_q[4];
   assign Out5    = lane_q[5];
   assign Out6    = lane_q[6];
   assign Out7    = lane_q[7];
   assign Valid   = valid_q;
   assign LastSel = last_q;

endmodule

// File: tb/tb_demux5.sv
// Self-checking testbench for demux5 with directed vectors.
// Inputs change on the falling edge; outputs are sampled on the falling edge,
// half a cycle after the rising edge that updated them.
module tb_demux5;

   logic       clk;
   logic       reset_n;
   logic [4:0] In;
   logic [2:0] Sel;
   logic       Load;
   logic       Clear;
   logic [4:0] Out0, Out1, Out2, Out3, Out4, Out5, Out6, Out7;
   logic [7:0] Valid;
   logic [2:0] LastSel;
   logic [4:0] got [8];
   logic [4:0] exp_out [8];

   int unsigned tests;
   int unsigned fails;

   demux5 dut (
      .clk     (clk),
      .reset_n (reset_n),
      .In      (In),
      .Sel     (Sel),
      .Load    (Load),
`ifdef DEMUX5_CLEAR_EN
      .Clear   (Clear),
`endif
      .Out0    (Out0),
      .Out1    (Out1),
      .Out2    (Out2),
      .Out3    (Out3),
      .Out4    (Out4),
      .Out5    (Out5),
      .Out6    (Out6),
      .Out7    (Out7),
      .Valid   (Valid),
      .LastSel (LastSel)
   );

   assign got[0] = Out0;
   assign got[1] = Out1;
   assign got[2] = Out2;
   assign got[3] = Out3;
   assign got[4] = Out4;
   assign got[5] = Out5;
   assign got[6] = Out6;
   assign got[7] = Out7;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] actual, input logic [31:0] expected);
      tests++;
      if (actual !== expected) begin
         fails++;
         $display("FAIL %s: got %0d expected %0d", tag, actual, expected);
      end
   endtask

   task automatic check_lanes(input string tag);
      for (int i = 0; i < 8; i++) begin
         check($sformatf("%s.out%0d", tag, i), 32'(got[i]), 32'(exp_out[i]));
      end
   endtask

   initial begin
      tests   = 0;
      fails   = 0;
      reset_n = 1'b0;
      Load    = 1'b0;
      Clear   = 1'b0;
      In      = '0;
      Sel     = '0;
      for (int i = 0; i < 8; i++) exp_out[i] = '0;

      // Reset state
      #2;
      check_lanes("reset");
      check("reset.valid", 32'(Valid), 32'h00);
      check("reset.lastsel", 32'(LastSel), 0);
      @(negedge clk);
      reset_n = 1'b1;

      // Single load: lane 3 <= 17
      In = 5'd17; Sel = 3'd3; Load = 1'b1;
      @(negedge clk);
      Load = 1'b0;
      exp_out[3] = 5'd17;
      check_lanes("single");
      check("single.valid", 32'(Valid), 32'h08);
      check("single.lastsel", 32'(LastSel), 3);
      @(negedge clk);
      check("single.valid_drop", 32'(Valid), 32'h00);
      check("single.out3_hold", 32'(Out3), 17);
      check("single.lastsel_hold", 32'(LastSel), 3);

      // Sweep all lanes back-to-back, In = Sel + 10
      for (int s = 0; s < 8; s++) begin
         Sel  = 3'(s);
         In   = 5'(s + 10);
         Load = 1'b1;
         @(negedge clk);
         exp_out[s] = 5'(s + 10);
         check($sformatf("sweep%0d.valid", s), 32'(Valid), 32'(8'h01 << s));
         check($sformatf("sweep%0d.lastsel", s), 32'(LastSel), 32'(s));
      end
      Load = 1'b0;
      check_lanes("sweep");

      // Same lane back-to-back: lane 5 <= 4 then 9
      Sel = 3'd5; In = 5'd4; Load = 1'b1;
      @(negedge clk);
      check("same1.out5", 32'(Out5), 4);
      check("same1.valid", 32'(Valid), 32'h20);
      In = 5'd9;
      @(negedge clk);
      Load = 1'b0;
      exp_out[5] = 5'd9;
      check("same2.valid", 32'(Valid), 32'h20);
      check_lanes("same2");
      @(negedge clk);
      check("same3.valid", 32'(Valid), 32'h00);

      // Idle hold with toggling In/Sel
      for (int c = 0; c < 20; c++) begin
         In  = 5'($urandom);
         Sel = (c == 7) ? 3'bxxx : 3'($urandom);
         @(negedge clk);
         check($sformatf("idle%0d.valid", c), 32'(Valid), 32'h00);
         check_lanes($sformatf("idle%0d", c));
      end
      check("idle.lastsel", 32'(LastSel), 5);

      // Asynchronous reset mid-cycle, checked before the next rising edge
      Sel = 3'd0;
      #2 reset_n = 1'b0;
      #1;
      for (int i = 0; i < 8; i++) exp_out[i] = '0;
      check_lanes("async_rst");
      check("async_rst.valid", 32'(Valid), 32'h00);
      check("async_rst.lastsel", 32'(LastSel), 0);
      #1 reset_n = 1'b1;
      @(negedge clk);
      // First edge after deassertion is a normal cycle
      Sel = 3'd7; In = 5'd31; Load = 1'b1;
      @(negedge clk);
      Load = 1'b0;
      exp_out[7] = 5'd31;
      check_lanes("post_rst");
      check("post_rst.valid", 32'(Valid), 32'h80);
      check("post_rst.lastsel", 32'(LastSel), 7);

`ifdef DEMUX5_CLEAR_EN
      // Preload lanes 0..6 with 20..26
      for (int s = 0; s < 7; s++) begin
         Sel = 3'(s); In = 5'(s + 20); Load = 1'b1;
         @(negedge clk);
      end
      // Clear and Load together on lane 2
      Sel = 3'd2; In = 5'd7; Load = 1'b1; Clear = 1'b1;
      @(negedge clk);
      Load = 1'b0; Clear = 1'b0;
      for (int i = 0; i < 8; i++) exp_out[i] = '0;
      exp_out[2] = 5'd7;
      check_lanes("clr_load");
      check("clr_load.valid", 32'(Valid), 32'h04);
      check("clr_load.lastsel", 32'(LastSel), 2);
      // Clear alone
      Sel = 3'd6; Clear = 1'b1;
      @(negedge clk);
      Clear = 1'b0;
      exp_out[2] = '0;
      check_lanes("clr_only");
      check("clr_only.valid", 32'(Valid), 32'h00);
      check("clr_only.lastsel", 32'(LastSel), 0);
`endif

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
